// File: rtl/rca_share_pkg.sv
// rtl/rca_share_pkg.sv - shared state type and index-width helper for the shared adder arbiter
package rca_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Index width for n requesters; never below one bit so ports stay legal.
   function automatic int calc_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/param_rca.sv
// rtl/param_rca.sv - parameterised ripple-carry adder with optional approximate low part
// APPROX low bits are OR-combined (no carry chain); the carry out of that part is a&b of its top bit.
module param_rca #(
   parameter int WIDTH  = 8,
   parameter int APPROX = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < APPROX) begin
            sum[i] = a[i] | b[i];
            c      = (i == APPROX - 1) ? (a[i] & b[i]) : 1'b0;
         end else begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         end
      end
      cout = c;
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts one past ptr
module rr_arbiter
   import rca_share_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = calc_idw(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   logic found;
   int   cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/rca_share_arbiter.sv
// rtl/rca_share_arbiter.sv - round-robin sharing of one param_rca between NREQ requesters
// Optional RCA_OPISO_EN: adder operands are forced to zero outside CALC.
module rca_share_arbiter
   import rca_share_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int APPROX = 0,
   parameter  int NREQ   = 4,
   localparam int IDW    = calc_idw(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_cout,
   output logic [IDW-1:0]        res_id,
   output logic                  busy
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] op_a, op_b, sum_q;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             cout_q, add_cout;
   logic [IDW-1:0]   id_q, ptr, win_idx;
   logic [NREQ-1:0]  win_gnt;
   logic             take;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (win_gnt),
      .idx (win_idx)
   );

`ifdef RCA_OPISO_EN
   assign add_a = op_a & {WIDTH{state == CALC}};
   assign add_b = op_b & {WIDTH{state == CALC}};
`else
   assign add_a = op_a;
   assign add_b = op_b;
`endif

   param_rca #(.WIDTH(WIDTH), .APPROX(APPROX)) u_rca (
      .a    (add_a),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = win_gnt;
            if (|req_valid) begin
               take     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC:    state_nx = HOLD;
         HOLD:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         id_q   <= '0;
         ptr    <= IDW'(NREQ - 1);
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            op_a <= req_a[int'(win_idx)*WIDTH +: WIDTH];
            op_b <= req_b[int'(win_idx)*WIDTH +: WIDTH];
            id_q <= win_idx;
            ptr  <= win_idx;
         end
         if (state == CALC) begin
            sum_q  <= add_sum;
            cout_q <= add_cout;
         end
      end
   end

   assign res_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// tb/tb_rca_share_arbiter.sv - self-checking bench: directed vectors, corner sequences, random vs model
module tb_rca_share_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid, req_ready;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic                  res_valid, res_ready, res_cout, busy;
   logic [WIDTH-1:0]      res_sum;
   logic [IDW-1:0]        res_id;

   rca_share_arbiter #(.WIDTH(WIDTH), .APPROX(0), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 1; k <= NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // One isolated transaction; entered and left just after a rising edge with the DUT idle.
   task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic co);
      set_op(id, a, b);
      req_valid = 4'(1 << id);
      @(negedge clk);
      check("grant", 32'(req_ready), 32'(1 << id));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("calc_busy", 32'(busy), 1);
      check("calc_novalid", 32'(res_valid), 0);
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 1);
      check("hold_sum", 32'(res_sum), 32'(s));
      check("hold_cout", 32'(res_cout), 32'(co));
      check("hold_id", 32'(res_id), 32'(id));
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("back_idle", 32'(busy), 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[6];

   int              exp_order[6];
   int              m_ptr, m_rdy_cyc, m_id, cyc, w;
   bit              m_busy;
   logic [8:0]      m_sum;
   logic [NREQ-1:0] hs, exp_ready;

   initial begin
      vecs[0] = '{0, 8'h3C, 8'h05, 8'h41, 1'b0};
      vecs[1] = '{2, 8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{1, 8'h80, 8'h80, 8'h00, 1'b1};
      vecs[3] = '{3, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{3, 8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[5] = '{0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
      exp_order = '{0, 1, 2, 3, 0, 3};

      rst = 1'b1; req_valid = '0; res_ready = 1'b0; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_sum", 32'(res_sum), 0);
      check("rst_cout", 32'(res_cout), 0);
      check("rst_id", 32'(res_id), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++)
         single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);

      // Round robin with all requesters asserted, then a sparse mask.
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, 8'(i*16 + 1), 8'(i));
      req_valid = 4'hF;
      res_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_grant", 32'(req_ready), 32'(1 << exp_order[k]));
         @(negedge clk);
         @(negedge clk);
         check("rr_valid", 32'(res_valid), 1);
         check("rr_id", 32'(res_id), 32'(exp_order[k]));
         check("rr_sum", 32'(res_sum), 32'(exp_order[k]*17 + 1));
         if (k == 3) req_valid = 4'b1001;
      end
      req_valid = '0;
      @(posedge clk); #1 res_ready = 1'b0;

      // Backpressure in HOLD with other requesters waiting.
      set_op(1, 8'hA5, 8'h3C);
      req_valid = 4'b0010;
      @(negedge clk);
      check("bp_grant", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = 4'hF;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(res_valid), 1);
         check("bp_sum", 32'(res_sum), 32'hE1);
         check("bp_cout", 32'(res_cout), 0);
         check("bp_id", 32'(res_id), 1);
         check("bp_noready", 32'(req_ready), 0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      check("bp_idle", 32'(busy), 0);
      check("bp_next", 32'(req_ready), 32'h4);
      req_valid = '0;
      @(posedge clk); #1;

      // Reset while in CALC.
      set_op(2, 8'h11, 8'h22);
      req_valid = 4'b0100;
      @(posedge clk); #1 req_valid = '0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rcalc_valid", 32'(res_valid), 0);
      check("rcalc_busy", 32'(busy), 0);
      @(negedge clk);
      check("rcalc_valid2", 32'(res_valid), 0);
      @(posedge clk); #1 req_valid = 4'hF;
      @(negedge clk);
      check("rcalc_grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0; res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 res_ready = 1'b0;

      // Reset while in HOLD.
      set_op(2, 8'h33, 8'h44);
      req_valid = 4'b0100;
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rhold_pre", 32'(res_valid), 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rhold_valid", 32'(res_valid), 0);
      check("rhold_busy", 32'(busy), 0);
      check("rhold_sum", 32'(res_sum), 0);
      @(posedge clk); #1 req_valid = 4'hF;
      @(negedge clk);
      check("rhold_grant", 32'(req_ready), 32'h1);
      req_valid = '0;
      @(posedge clk); #1;

      // Random traffic against a transaction-level model.
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      m_ptr = NREQ - 1; m_busy = 1'b0; m_rdy_cyc = 0; cyc = 0; hs = '0;
      m_sum = '0; m_id = 0;
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         req_valid = req_valid & ~hs;
         hs = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[i] = 1'b1;
                  set_op(i, 8'($urandom), 8'($urandom));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cyc++;
         check("rnd_busy", 32'(busy), 32'(m_busy));
`ifdef RCA_OPISO_EN
         if (!(m_busy && cyc == m_rdy_cyc - 1)) begin
            check("iso_a", 32'(dut.add_a), 0);
            check("iso_b", 32'(dut.add_b), 0);
         end
`endif
         if (!m_busy) begin
            exp_ready = '0;
            if (req_valid != '0) begin
               w         = rr_pick(req_valid, m_ptr);
               exp_ready = 4'(1 << w);
               m_ptr     = w;
               m_id      = w;
               m_sum     = {1'b0, req_a[w*WIDTH +: WIDTH]} + {1'b0, req_b[w*WIDTH +: WIDTH]};
               m_busy    = 1'b1;
               m_rdy_cyc = cyc + 2;
               hs        = exp_ready;
            end
            check("rnd_ready", 32'(req_ready), 32'(exp_ready));
            check("rnd_novalid", 32'(res_valid), 0);
         end else begin
            check("rnd_noready", 32'(req_ready), 0);
            check("rnd_valid", 32'(res_valid), 32'(cyc >= m_rdy_cyc));
            if (cyc >= m_rdy_cyc) begin
               check("rnd_sum", 32'(res_sum), 32'(m_sum[7:0]));
               check("rnd_cout", 32'(res_cout), 32'(m_sum[8]));
               check("rnd_id", 32'(res_id), 32'(m_id));
               if (res_ready) m_busy = 1'b0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
